// File: rtl/fwd_hazard_unit_if.sv
// fwd_hazard_unit_if: pipeline-side (master) and hazard-unit-side (slave) bundle of F/D, D/X, X/M, M/W fields, forward selects, stall and scoreboard.
interface fwd_hazard_unit_if #(parameter int LANES = 2, parameter int RW = 5, parameter int CNTW = 32);
  localparam int SELW = $clog2(2*LANES+1);
  logic [LANES-1:0]      fd_valid;
  logic [LANES*RW-1:0]   fd_rs;
  logic [LANES*RW-1:0]   fd_rt;
  logic [LANES*RW-1:0]   fd_rd;
  logic [LANES-1:0]      fd_md_start;
  logic [LANES*RW-1:0]   dx_rs;
  logic [LANES*RW-1:0]   dx_rt;
  logic [LANES*RW-1:0]   dx_rd;
  logic [LANES-1:0]      dx_load;
  logic [LANES*RW-1:0]   xm_rd;
  logic [LANES*RW-1:0]   mw_rd;
  logic [LANES-1:0]      xm_regwrite;
  logic [LANES-1:0]      mw_regwrite;
  logic                  md_done;
  logic [RW-1:0]         md_rd;
  logic                  stall;
  logic [LANES*SELW-1:0] fwd_a;
  logic [LANES*SELW-1:0] fwd_b;
  logic [2**RW-1:0]      sb_pending;
  logic [CNTW-1:0]       stall_count;
  modport master (
    output fd_valid, fd_rs, fd_rt, fd_rd, fd_md_start, dx_rs, dx_rt, dx_rd, dx_load,
           xm_rd, mw_rd, xm_regwrite, mw_regwrite, md_done, md_rd,
    input  stall, fwd_a, fwd_b, sb_pending, stall_count
  );
  modport slave (
    input  fd_valid, fd_rs, fd_rt, fd_rd, fd_md_start, dx_rs, dx_rt, dx_rd, dx_load,
           xm_rd, mw_rd, xm_regwrite, mw_regwrite, md_done, md_rd,
    output stall, fwd_a, fwd_b, sb_pending, stall_count
  );
endinterface

// File: rtl/fwd_hazard_unit.sv
// fwd_hazard_unit: per-lane operand forward selects, load-use and mult/div scoreboard stall, saturating stall counter (ports: clk_i, rst_i, bus slave).
module fwd_hazard_unit #(
  parameter int LANES = 2,
  parameter int RW = 5,
  parameter int CNTW = 32
) (
  input logic clk_i,
  input logic rst_i,
  fwd_hazard_unit_if.slave bus
);
  localparam int SELW = $clog2(2*LANES+1);
  localparam int NREG = 2**RW;
  logic [NREG-1:0] pend_q, pend_d;
  logic [CNTW-1:0] cnt_q, cnt_d;
  logic lu, sbh, stall;
  // M/W scanned first and X/M last so X/M wins; ascending k lets the later lane win
  function automatic logic [SELW-1:0] sel(input logic [RW-1:0] s, input logic [LANES*RW-1:0] xr,
                                          input logic [LANES*RW-1:0] mr, input logic [LANES-1:0] xw,
                                          input logic [LANES-1:0] mw);
    logic [SELW-1:0] r;
    r = '0;
    for (int k = 0; k < LANES; k++) if (mw[k] && mr[k*RW +: RW] == s) r = SELW'(1 + LANES + k);
    for (int k = 0; k < LANES; k++) if (xw[k] && xr[k*RW +: RW] == s) r = SELW'(1 + k);
    return (s == '0) ? '0 : r;
  endfunction
  always_comb begin
    bus.fwd_a = '0;
    bus.fwd_b = '0;
    for (int i = 0; i < LANES; i++) begin
      bus.fwd_a[i*SELW +: SELW] = sel(bus.dx_rs[i*RW +: RW], bus.xm_rd, bus.mw_rd, bus.xm_regwrite, bus.mw_regwrite);
      bus.fwd_b[i*SELW +: SELW] = sel(bus.dx_rt[i*RW +: RW], bus.xm_rd, bus.mw_rd, bus.xm_regwrite, bus.mw_regwrite);
    end
  end
  always_comb begin
    lu = 1'b0;
    sbh = 1'b0;
    pend_d = pend_q;
    for (int i = 0; i < LANES; i++) begin
      if (bus.fd_valid[i]) begin
        for (int j = 0; j < LANES; j++)
          if (bus.dx_load[j])
            lu = lu | (bus.fd_rs[i*RW +: RW] != '0 && bus.fd_rs[i*RW +: RW] == bus.dx_rd[j*RW +: RW])
                    | (bus.fd_rt[i*RW +: RW] != '0 && bus.fd_rt[i*RW +: RW] == bus.dx_rd[j*RW +: RW]);
        sbh = sbh | (bus.fd_rs[i*RW +: RW] != '0 && pend_q[bus.fd_rs[i*RW +: RW]])
                  | (bus.fd_rt[i*RW +: RW] != '0 && pend_q[bus.fd_rt[i*RW +: RW]])
                  | (bus.fd_md_start[i] && pend_q[bus.fd_rd[i*RW +: RW]]);
      end
    end
    stall = !rst_i && (lu || sbh);
    // clear first so a same-cycle set of the same register overrides it
    if (bus.md_done) pend_d[bus.md_rd] = 1'b0;
    for (int i = 0; i < LANES; i++)
      if (bus.fd_valid[i] && bus.fd_md_start[i] && bus.fd_rd[i*RW +: RW] != '0 && !stall)
        pend_d[bus.fd_rd[i*RW +: RW]] = 1'b1;
    cnt_d = cnt_q + CNTW'(stall && !(&cnt_q));
  end
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      pend_q <= '0;
      cnt_q <= '0;
    end else begin
      pend_q <= pend_d;
      cnt_q <= cnt_d;
    end
  end
  assign bus.stall = stall;
  assign bus.sb_pending = pend_q;
  assign bus.stall_count = cnt_q;
endmodule

// File: tb/tb_fwd_hazard_unit.sv
// tb_fwd_hazard_unit: directed checks of forward selects, load-use and scoreboard stalls, counter saturation and reset.
module tb_fwd_hazard_unit;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int total = 0;
  int bad = 0;
  always #5 clk = ~clk;
  fwd_hazard_unit_if #(.LANES(2), .RW(5), .CNTW(4)) bus();
  fwd_hazard_unit #(.LANES(2), .RW(5), .CNTW(4)) dut (.clk_i(clk), .rst_i(rst), .bus(bus));
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic clr();
    bus.fd_valid = '0; bus.fd_rs = '0; bus.fd_rt = '0; bus.fd_rd = '0; bus.fd_md_start = '0;
    bus.dx_rs = '0; bus.dx_rt = '0; bus.dx_rd = '0; bus.dx_load = '0;
    bus.xm_rd = '0; bus.mw_rd = '0; bus.xm_regwrite = '0; bus.mw_regwrite = '0;
    bus.md_done = 1'b0; bus.md_rd = '0;
  endtask
  task automatic edge1();
    @(posedge clk);
    #1;
  endtask
  initial begin
    clr();
    edge1();
    chk("rst_pending", 64'(bus.sb_pending), 64'd0);
    chk("rst_count", 64'(bus.stall_count), 64'd0);
    chk("rst_stall", 64'(bus.stall), 64'd0);
    rst = 1'b0;
    bus.xm_rd = {5'd5, 5'd5}; bus.xm_regwrite = 2'b11;
    bus.mw_rd = {5'd0, 5'd5}; bus.mw_regwrite = 2'b01;
    bus.dx_rs = {5'd0, 5'd5};
    #1;
    chk("fwd_a_xm_hi", 64'(bus.fwd_a), 64'b000_010);
    chk("fwd_b_r0", 64'(bus.fwd_b), 64'd0);
    clr();
    bus.mw_rd = {5'd7, 5'd0}; bus.mw_regwrite = 2'b10; bus.dx_rt = {5'd7, 5'd0};
    #1;
    chk("fwd_b_mw1", 64'(bus.fwd_b), 64'b100_000);
    bus.mw_regwrite = 2'b00;
    #1;
    chk("fwd_b_nowr", 64'(bus.fwd_b), 64'd0);
    clr();
    bus.mw_rd = {5'd6, 5'd6}; bus.mw_regwrite = 2'b11; bus.dx_rs = {5'd6, 5'd0};
    bus.xm_rd = {5'd0, 5'd8}; bus.xm_regwrite = 2'b01; bus.dx_rt = {5'd0, 5'd8};
    #1;
    chk("fwd_a_mw_hi", 64'(bus.fwd_a), 64'b100_000);
    chk("fwd_b_xm0", 64'(bus.fwd_b), 64'b000_001);
    clr();
    bus.dx_load = 2'b01; bus.dx_rd = {5'd0, 5'd3};
    bus.fd_valid = 2'b10; bus.fd_rs = {5'd3, 5'd0};
    #1;
    chk("lu_stall", 64'(bus.stall), 64'd1);
    edge1();
    bus.dx_load = 2'b00; bus.dx_rd = '0;
    #1;
    chk("lu_release", 64'(bus.stall), 64'd0);
    chk("lu_count", 64'(bus.stall_count), 64'd1);
    clr();
    bus.dx_load = 2'b01; bus.fd_valid = 2'b01;
    #1;
    chk("lu_r0", 64'(bus.stall), 64'd0);
    clr();
    bus.fd_valid = 2'b01; bus.fd_md_start = 2'b01; bus.fd_rd = {5'd0, 5'd9};
    #1;
    chk("md_issue", 64'(bus.stall), 64'd0);
    edge1();
    chk("sb_set9", 64'(bus.sb_pending), 64'h200);
    bus.fd_md_start = '0; bus.fd_rd = '0; bus.fd_rs = {5'd0, 5'd9};
    #1;
    chk("sb_stall", 64'(bus.stall), 64'd1);
    for (int n = 0; n < 3; n++) edge1();
    bus.md_done = 1'b1; bus.md_rd = 5'd9;
    #1;
    chk("sb_no_bypass", 64'(bus.stall), 64'd1);
    edge1();
    bus.md_done = 1'b0;
    #1;
    chk("sb_release", 64'(bus.stall), 64'd0);
    chk("sb_cleared", 64'(bus.sb_pending), 64'd0);
    chk("sb_count", 64'(bus.stall_count), 64'd5);
    clr();
    bus.md_done = 1'b1; bus.md_rd = 5'd9;
    bus.fd_valid = 2'b11; bus.fd_md_start = 2'b11; bus.fd_rd = {5'd9, 5'd10};
    edge1();
    chk("set_wins", 64'(bus.sb_pending), 64'h600);
    clr();
    bus.fd_valid = 2'b01; bus.fd_md_start = 2'b01; bus.fd_rd = {5'd0, 5'd10};
    #1;
    chk("waw_stall", 64'(bus.stall), 64'd1);
    clr();
    bus.fd_valid = 2'b01; bus.fd_rt = {5'd0, 5'd10};
    for (int n = 0; n < 20; n++) edge1();
    chk("sat_count", 64'(bus.stall_count), 64'd15);
    chk("sat_stall", 64'(bus.stall), 64'd1);
    rst = 1'b1;
    #1;
    chk("rst_stall_drop", 64'(bus.stall), 64'd0);
    edge1();
    chk("rst_count0", 64'(bus.stall_count), 64'd0);
    chk("rst_pend0", 64'(bus.sb_pending), 64'd0);
    rst = 1'b0;
    #1;
    chk("post_rst_stall", 64'(bus.stall), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
